// File: rtl/approx_mult_pipe.sv
// Two-stage valid/ready pipelined unsigned multiplier with selectable exact/approximate product.
// Define APPROX_ERR_MON_EN to compile in the approximation error monitor (clr_stats, err_cnt, err_sum).
module approx_mult_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned L     = 4,
  parameter int unsigned K     = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
`ifdef APPROX_ERR_MON_EN
  ,
  input  logic               clr_stats,
  output logic [31:0]        err_cnt,
  output logic [47:0]        err_sum
`endif
);

  localparam int unsigned PW = 2 * WIDTH;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_mode_q, s1_mode_d;
  logic [PW-1:0] s1_hi_q, s1_hi_d;
  logic [PW-1:0] s1_lo_kept_q, s1_lo_kept_d;
  logic [PW-1:0] s1_lo_full_q, s1_lo_full_d;
  logic          s2_valid_q, s2_valid_d;
  logic [PW-1:0] z_q, z_d;

  logic          s2_adv, s1_adv, accept;
  logic [PW-1:0] pp_hi, pp_kept, pp_full;

`ifdef APPROX_ERR_MON_EN
  logic [PW-1:0] s2_exact_q, s2_exact_d;
  logic          s2_mode_q, s2_mode_d;
  logic [31:0]   err_cnt_q, err_cnt_d;
  logic [47:0]   err_sum_q, err_sum_d;
  logic [PW-1:0] err;
  logic [64:0]   sum_wide;
`endif

  // Rows i >= L form the exact upper product; low rows are summed both in full
  // (for exact mode) and with columns below K dropped (for approximate mode).
  always_comb begin
    pp_hi   = '0;
    pp_kept = '0;
    pp_full = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (x[i]) begin
        if (i < L) begin
          pp_full = pp_full + (PW'(y) << i);
          for (int unsigned j = 0; j < WIDTH; j++) begin
            if (y[j] && (i + j >= K)) pp_kept = pp_kept + (PW'(1) << (i + j));
          end
        end else begin
          pp_hi = pp_hi + (PW'(y) << i);
        end
      end
    end
  end

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = !rst && s1_adv;
    accept   = in_valid && in_ready;

    s1_valid_d   = s1_valid_q;
    s1_mode_d    = s1_mode_q;
    s1_hi_d      = s1_hi_q;
    s1_lo_kept_d = s1_lo_kept_q;
    s1_lo_full_d = s1_lo_full_q;
    s2_valid_d   = s2_valid_q;
    z_d          = z_q;

    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_mode_d    = mode;
        s1_hi_d      = pp_hi;
        s1_lo_kept_d = pp_kept;
        s1_lo_full_d = pp_full;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) z_d = s1_hi_q + (s1_mode_q ? s1_lo_full_q : s1_lo_kept_q);
    end
  end

`ifdef APPROX_ERR_MON_EN
  always_comb begin
    s2_exact_d = s2_exact_q;
    s2_mode_d  = s2_mode_q;
    if (s2_adv && s1_valid_q) begin
      s2_exact_d = s1_hi_q + s1_lo_full_q;
      s2_mode_d  = s1_mode_q;
    end

    err       = s2_exact_q - z_q;
    sum_wide  = {17'b0, err_sum_q} + 65'(err);
    err_cnt_d = err_cnt_q;
    err_sum_d = err_sum_q;
    if (clr_stats) begin
      err_cnt_d = '0;
      err_sum_d = '0;
    end else if (s2_valid_q && out_ready && !s2_mode_q) begin
      if (err != '0 && err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
      err_sum_d = (sum_wide[64:48] != '0) ? '1 : sum_wide[47:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= '0;
      s1_mode_q    <= '0;
      s1_hi_q      <= '0;
      s1_lo_kept_q <= '0;
      s1_lo_full_q <= '0;
      s2_valid_q   <= '0;
      z_q          <= '0;
`ifdef APPROX_ERR_MON_EN
      s2_exact_q   <= '0;
      s2_mode_q    <= '0;
      err_cnt_q    <= '0;
      err_sum_q    <= '0;
`endif
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_hi_q      <= s1_hi_d;
      s1_lo_kept_q <= s1_lo_kept_d;
      s1_lo_full_q <= s1_lo_full_d;
      s2_valid_q   <= s2_valid_d;
      z_q          <= z_d;
`ifdef APPROX_ERR_MON_EN
      s2_exact_q   <= s2_exact_d;
      s2_mode_q    <= s2_mode_d;
      err_cnt_q    <= err_cnt_d;
      err_sum_q    <= err_sum_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign z         = z_q;
`ifdef APPROX_ERR_MON_EN
  assign err_cnt   = err_cnt_q;
  assign err_sum   = err_sum_q;
`endif

endmodule
